// File: rtl/debounce_pkg.sv
// Shared constants and sizing helpers for the debounce bank.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, edge pulses and long-press detect.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_lvl;
    logic                   flip;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing ticks.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_i ^ ACTIVE_LOW};
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        flip      = 1'b0;
        if (sync_lvl == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_lvl;
                cnt_d    = '0;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d   = flip & sync_lvl;
        release_d = flip & ~sync_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_o           = stable_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

    if (LONG_CYCLES > 0) begin : g_long
        localparam int unsigned HW = cnt_width(LONG_CYCLES + 1);

        logic [HW-1:0] hold_q, hold_d;
        logic          sat_q;
        logic          long_q, long_d;

        // sat_q lags the saturated hold count so the pulse fires once per press.
        always_comb begin
            hold_d = hold_q;
            if (!stable_q) begin
                hold_d = '0;
            end else if (tick_i && (hold_q != HW'(LONG_CYCLES))) begin
                hold_d = hold_q + HW'(1);
            end
            long_d = (hold_q == HW'(LONG_CYCLES)) && !sat_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
                sat_q  <= 1'b0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                sat_q  <= (hold_q == HW'(LONG_CYCLES));
                long_q <= long_d;
            end
        end

        assign long_pulse_o = long_q;
    end else begin : g_no_long
        assign long_pulse_o = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one tick enable.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .tick_i          (tick),
            .btn_i           (btn_in[i]),
            .btn_o           (btn_out[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i]),
            .long_pulse_o    (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed table, corner sequences and random traffic vs a model.
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int LC = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b1;
    logic [N-1:0] btn_in = '1;
    logic [N-1:0] btn_out, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .btn_in        (btn_in),
        .btn_out       (btn_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    // Reference: pressed level seen after two clocks, run length of disagreeing ticks, ticks held.
    int  m_s0[N], m_s1[N], m_level[N], m_run[N], m_held[N], m_full[N];
    bit  m_press[N], m_rel[N], m_long[N];

    int checks = 0;
    int errors = 0;
    int n_press, n_rel, n_long;
    int cyc = 0;

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_s0[c] = 0; m_s1[c] = 0; m_level[c] = 0; m_run[c] = 0;
            m_held[c] = 0; m_full[c] = 0;
            m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
        end
    endfunction

    function automatic void model_step(logic t, logic [N-1:0] b);
        for (int c = 0; c < N; c++) begin
            int  run_n   = m_run[c];
            int  level_n = m_level[c];
            bit  flip    = 0;
            if (m_s1[c] == m_level[c]) run_n = 0;
            else if (t) begin
                run_n = run_n + 1;
                if (run_n == DC) begin
                    flip    = 1;
                    level_n = m_s1[c];
                    run_n   = 0;
                end
            end
            m_long[c] = (m_held[c] == LC) && (m_full[c] == 0);
            m_full[c] = (m_held[c] == LC) ? 1 : 0;
            if (m_level[c] == 0) m_held[c] = 0;
            else if (t && m_held[c] < LC) m_held[c] = m_held[c] + 1;
            m_press[c] = flip && (m_s1[c] == 1);
            m_rel[c]   = flip && (m_s1[c] == 0);
            m_level[c] = level_n;
            m_run[c]   = run_n;
            m_s1[c]    = m_s0[c];
            m_s0[c]    = b[c] ? 0 : 1;
        end
    endfunction

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock: advance model at the edge, compare 1 time unit later.
    task automatic step();
        logic [N-1:0] e_out, e_pr, e_rl, e_lg;
        @(posedge clk);
        if (rst_n) model_step(tick, btn_in);
        else model_reset();
        #1;
        for (int c = 0; c < N; c++) begin
            e_out[c] = (m_level[c] != 0);
            e_pr[c]  = m_press[c];
            e_rl[c]  = m_rel[c];
            e_lg[c]  = m_long[c];
        end
        check_vec("model_btn_out", btn_out, e_out);
        check_vec("model_press", press_pulse, e_pr);
        check_vec("model_release", release_pulse, e_rl);
        check_vec("model_long", long_pulse, e_lg);
        n_press += $countones(press_pulse);
        n_rel   += $countones(release_pulse);
        n_long  += $countones(long_pulse);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        btn_in = '1;
        tick = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    typedef struct {
        logic [N-1:0] btn;
        int           ncyc;
        logic [N-1:0] exp_out;
        int           exp_press;
        int           exp_rel;
        int           exp_long;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int lat;
        int rate;
        bit rnd_tick;

        tbl[0]  = '{4'hF, 5,  4'b0000, 0, 0, 0};
        tbl[1]  = '{4'hE, 9,  4'b0000, 0, 0, 0};
        tbl[2]  = '{4'hE, 1,  4'b0001, 1, 0, 0};
        tbl[3]  = '{4'hE, 20, 4'b0001, 0, 0, 0};
        tbl[4]  = '{4'hE, 1,  4'b0001, 0, 0, 1};
        tbl[5]  = '{4'hE, 10, 4'b0001, 0, 0, 0};
        tbl[6]  = '{4'hF, 9,  4'b0001, 0, 0, 0};
        tbl[7]  = '{4'hF, 1,  4'b0000, 0, 1, 0};
        tbl[8]  = '{4'hB, 7,  4'b0000, 0, 0, 0};
        tbl[9]  = '{4'hF, 12, 4'b0000, 0, 0, 0};
        tbl[10] = '{4'h0, 10, 4'b1111, 4, 0, 0};
        tbl[11] = '{4'hF, 10, 4'b0000, 0, 4, 0};

        model_reset();
        #1;
        check_vec("reset_btn_out", btn_out, '0);
        check_vec("reset_press", press_pulse, '0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            btn_in = tbl[i].btn;
            n_press = 0; n_rel = 0; n_long = 0;
            repeat (tbl[i].ncyc) step();
            check_vec($sformatf("tbl%0d_out", i), btn_out, tbl[i].exp_out);
            check_int($sformatf("tbl%0d_press", i), n_press, tbl[i].exp_press);
            check_int($sformatf("tbl%0d_release", i), n_rel, tbl[i].exp_rel);
            check_int($sformatf("tbl%0d_long", i), n_long, tbl[i].exp_long);
        end

        // Bounce on ch1 then settle pressed.
        do_reset();
        n_press = 0; n_rel = 0;
        for (int k = 0; k < 8; k++) begin
            btn_in[1] = k[0];
            repeat (3) step();
        end
        check_int("bounce_no_early_press", n_press, 0);
        btn_in[1] = 1'b0;
        lat = 0;
        while (!press_pulse[1] && lat < 50) begin step(); lat++; end
        check_int("bounce_latency", lat, DC + 2);
        repeat (15) step();
        check_int("bounce_press_count", n_press, 1);
        check_int("bounce_release_count", n_rel, 0);

        // Tick gating: one tick in four.
        do_reset();
        btn_in[0] = 1'b0;
        lat = 0;
        while (!btn_out[0] && lat < 100) begin
            tick = (lat % 4 == 0);
            step();
            lat++;
        end
        tick = 1'b1;
        checks++;
        if (lat < 31 || lat > 35) begin
            errors++;
            $display("FAIL tick_gate_latency cyc=%0d actual=%0d expected=31..35", cyc, lat);
        end

        // Reset mid-count, then again with the button already debounced.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            btn_in = 4'hE;
            repeat (pass == 0 ? 7 : 12) step();
            if (pass == 1) check_vec("pre_reset_btn_out", btn_out, 4'b0001);
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_vec("async_reset_btn_out", btn_out, '0);
            check_vec("async_reset_press", press_pulse, '0);
            check_vec("async_reset_release", release_pulse, '0);
            repeat (3) step();
            rst_n = 1'b1;
            n_rel = 0;
            lat = 0;
            while (!press_pulse[0] && lat < 50) begin step(); lat++; end
            check_int("post_reset_press_latency", lat, DC + 2);
            repeat (5) step();
            check_int("post_reset_no_release", n_rel, 0);
        end

        // Random traffic against the model.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0:       rate = 4;
                1:       rate = 15;
                default: rate = 40;
            endcase
            rnd_tick = (blk >= 3);
            for (int i = 0; i < 500; i++) begin
                for (int c = 0; c < N; c++)
                    if ($urandom_range(rate - 1) == 0) btn_in[c] = ~btn_in[c];
                tick = rnd_tick ? 1'($urandom_range(1)) : 1'b1;
                if ($urandom_range(399) == 0) begin
                    rst_n = 1'b0;
                    model_reset();
                    repeat (2) step();
                    rst_n = 1'b1;
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
